uart_rx_sequencer: RTL and testbench

//  Sequences the UART receive path. Enables the start-bit detector while idle, then qualifies the

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_sequencer.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit sequencer states and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the serial line; resets to the idle (high) level.
module uart_sync2 (
    input  logic Clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start qualification, mid-bit data/parity/stop sampling on the
// oversampled baud grid, and valid/ready hand-off of each received byte with error flags.
//
// state  | meaning
// IDLE   | start-bit detector enabled, waiting for start_bit_in
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling data bits LSB-first, one per bit period
// PARITY | sampling and checking the parity bit
// STOP   | sampling the stop bit, loading the output register
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 i_rx_in,
    input  logic                 i_baud_tick,
    input  logic                 i_start_bit_in,
    output logic                 o_startbit_det_en,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun_err,
    output logic                 o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun_err;
    logic                 w_rx_s;
    logic                 w_tick_half;
    logic                 w_tick_full;
    logic                 w_tick_clr;
    logic                 w_load;
    logic                 w_det_en;

    uart_sync2 u_sync (
        .Clk   (Clk),
        .reset (reset),
        .i_d   (i_rx_in),
        .o_q   (w_rx_s)
    );

    assign w_tick_half = i_baud_tick && (r_tick_cnt == TC_HALF);
    assign w_tick_full = i_baud_tick && (r_tick_cnt == TC_FULL);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_det_en    = 1'b0;
        w_tick_clr  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_det_en   = 1'b1;
                w_tick_clr = 1'b1;
                if (i_start_bit_in) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // Restarting the tick count here moves the sampling phase to mid-bit.
                if (w_tick_half) begin
                    w_tick_clr  = 1'b1;
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick_full && (r_bit_cnt == BC_LAST)) begin
                    w_state_nxt = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_tick_full) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at the mid-stop sample so a back-to-back start edge is not missed.
                if (w_tick_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            if (w_tick_clr) begin
                r_tick_cnt <= '0;
            end else if (i_baud_tick) begin
                r_tick_cnt <= (r_tick_cnt == TC_FULL) ? '0 : r_tick_cnt + 1'b1;
            end
            if (r_state == START) begin
                r_bit_cnt <= '0;
            end else if ((r_state == DATA) && w_tick_full) begin
                r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_par_err <= 1'b0;
        end else if (r_state == START) begin
            r_par_err <= 1'b0;
        end else if ((r_state == PARITY) && w_tick_full) begin
            r_par_err <= w_rx_s ^ (^r_shift) ^ PAR_ODD;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (w_load) begin
            // A simultaneous accept consumes the old byte, so only an unaccepted one overruns.
            r_data_out   <= r_shift;
            r_data_valid <= 1'b1;
            r_frame_err  <= ~w_rx_s;
            r_parity_err <= PAR_EN & r_par_err;
            if (r_data_valid && !i_data_ready) begin
                r_overrun_err <= 1'b1;
            end
        end else if (r_data_valid && i_data_ready) begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end
    end

    assign o_startbit_det_en = w_det_en;
    assign o_busy            = (r_state != IDLE);
    assign o_data_out        = r_data_out;
    assign o_data_valid      = r_data_valid;
    assign o_frame_err       = r_frame_err;
    assign o_parity_err      = r_parity_err;
    assign o_overrun_err     = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: an 8N1 and an 8E1 instance driven by a tick-accurate line
// generator, checked against a frame-level model of the byte/flag/handshake outcome.
module tb_uart_rx_sequencer;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    logic tx_line = 1'b1;
    logic start_pulse = 1'b0;
    logic data_ready = 1'b0;
    logic mode_p = 1'b0;
    logic i_baud_tick = 1'b0;
    int   ph = 0;

    logic       rx0, st0, rdy0, det0, val0, fe0, pe0, ovr0, busy0;
    logic       rx1, st1, rdy1, det1, val1, fe1, pe1, ovr1, busy1;
    logic [7:0] dat0, dat1;
    logic       s_det, s_valid, s_fe, s_pe, s_ovr, s_busy, s_busy_q;
    logic [7:0] s_data;

    int n_vec = 0;
    int n_err = 0;
    int busy_rises = 0;

    bit         m_valid [2];
    logic [7:0] m_data  [2];
    bit         m_fe    [2];
    bit         m_pe    [2];
    bit         m_ovr   [2];

    always #5 Clk = ~Clk;

    assign rx0  = mode_p ? 1'b1 : tx_line;
    assign st0  = mode_p ? 1'b0 : start_pulse;
    assign rdy0 = mode_p ? 1'b0 : data_ready;
    assign rx1  = mode_p ? tx_line : 1'b1;
    assign st1  = mode_p ? start_pulse : 1'b0;
    assign rdy1 = mode_p ? data_ready : 1'b0;

    assign s_det   = mode_p ? det1  : det0;
    assign s_valid = mode_p ? val1  : val0;
    assign s_data  = mode_p ? dat1  : dat0;
    assign s_fe    = mode_p ? fe1   : fe0;
    assign s_pe    = mode_p ? pe1   : pe0;
    assign s_ovr   = mode_p ? ovr1  : ovr0;
    assign s_busy  = mode_p ? busy1 : busy0;

    uart_rx_sequencer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .Clk(Clk), .reset(reset), .i_rx_in(rx0), .i_baud_tick(i_baud_tick),
        .i_start_bit_in(st0), .o_startbit_det_en(det0), .o_data_out(dat0),
        .o_data_valid(val0), .i_data_ready(rdy0), .o_frame_err(fe0),
        .o_parity_err(pe0), .o_overrun_err(ovr0), .o_busy(busy0)
    );

    uart_rx_sequencer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
        .Clk(Clk), .reset(reset), .i_rx_in(rx1), .i_baud_tick(i_baud_tick),
        .i_start_bit_in(st1), .o_startbit_det_en(det1), .o_data_out(dat1),
        .o_data_valid(val1), .i_data_ready(rdy1), .o_frame_err(fe1),
        .o_parity_err(pe1), .o_overrun_err(ovr1), .o_busy(busy1)
    );

    always @(posedge Clk) begin
        s_busy_q <= s_busy;
        if (s_busy && !s_busy_q) busy_rises <= busy_rises + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one Clk: advance to the falling edge and drive the baud tick (one in three clocks)
    task automatic step();
        @(negedge Clk);
        ph = (ph == 2) ? 0 : ph + 1;
        i_baud_tick = (ph == 0);
    endtask

    task automatic check_all(input string tag);
        int p;
        p = mode_p ? 1 : 0;
        chk({tag, "_valid"}, s_valid, m_valid[p]);
        chk({tag, "_data"},  s_data,  m_data[p]);
        chk({tag, "_ferr"},  s_fe,    m_fe[p]);
        chk({tag, "_perr"},  s_pe,    m_pe[p]);
        chk({tag, "_ovr"},   s_ovr,   m_ovr[p]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tx_line = 1'b1;
        start_pulse = 1'b0;
        data_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_data[i] = 8'h00; m_fe[i] = 0; m_pe[i] = 0; m_ovr[i] = 0;
        end
        check_all("reset");
        chk("reset_busy", s_busy, 0);
        reset = 1'b0;
        step();
        chk("reset_det_en", s_det, 1);
    endtask

    task automatic accept();
        int p;
        p = mode_p ? 1 : 0;
        step();
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        if (m_valid[p]) begin
            m_valid[p] = 0; m_fe[p] = 0; m_pe[p] = 0;
        end
        check_all("accept");
    endtask

    // Line bit k occupies ticks [16k, 16k+16) counted from the start edge.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input bit acc_load, input int abort_tick);
        logic fb [0:10];
        int   p, nb, cnt, load_t, end_t;
        bit   post;
        p = mode_p ? 1 : 0;
        nb = mode_p ? 11 : 10;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        if (mode_p) begin
            fb[9] = pbit; fb[10] = sbit;
        end else begin
            fb[9] = sbit; fb[10] = 1'b1;
        end
        load_t = 16 * (nb - 1) + 8;
        end_t  = 16 * nb;
        step();
        tx_line = 1'b0;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        cnt = 0;
        post = 0;
        while (cnt < end_t) begin
            if (post) begin
                data_ready = 1'b0;
                post = 0;
                chk("load_latency_valid", s_valid, 1);
                if (m_valid[p] && !acc_load) m_ovr[p] = 1;
                m_valid[p] = 1;
                m_data[p]  = d;
                m_fe[p]    = ~sbit;
                m_pe[p]    = mode_p ? (pbit != ^d) : 0;
            end
            if (i_baud_tick) begin
                cnt++;
                if (cnt == abort_tick) begin
                    do_reset();
                    return;
                end
                if (cnt == load_t) begin
                    chk("pre_load_valid", s_valid, m_valid[p]);
                    data_ready = acc_load;
                    post = 1;
                end
            end
            if (cnt < end_t) tx_line = fb[cnt/16];
            step();
        end
        tx_line = 1'b1;
    endtask

    task automatic glitch();
        int cnt, r0, p;
        p = mode_p ? 1 : 0;
        r0 = busy_rises;
        step();
        tx_line = 1'b0;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        cnt = 0;
        while (cnt < 24) begin
            if (i_baud_tick) cnt++;
            if (cnt >= 4) tx_line = 1'b1;
            step();
        end
        step();
        chk("glitch_busy_pulses", busy_rises - r0, 1);
        chk("glitch_busy", s_busy, 0);
        chk("glitch_valid", s_valid, m_valid[p]);
        chk("glitch_det_en", s_det, 1);
    endtask

    initial begin
        logic [7:0] d;
        logic       sb, pb;
        int         am;

        step();
        do_reset();

        send_frame(8'hA5, 1'b0, 1'b1, 0, -1);
        check_all("t1");
        accept();

        glitch();

        send_frame(8'h3C, 1'b0, 1'b0, 0, -1);
        check_all("t3");
        accept();

        send_frame(8'h11, 1'b0, 1'b1, 0, -1);
        send_frame(8'h22, 1'b0, 1'b1, 0, -1);
        check_all("t5_overrun");
        accept();
        chk("t5_sticky", s_ovr, 1);
        do_reset();
        send_frame(8'h33, 1'b0, 1'b1, 0, -1);
        send_frame(8'h44, 1'b0, 1'b1, 1, -1);
        check_all("t5_same_cycle");
        accept();

        send_frame(8'h99, 1'b0, 1'b1, 0, 16 * 4 + 6);
        send_frame(8'h5A, 1'b0, 1'b1, 0, -1);
        check_all("t6");
        accept();

        for (int k = 0; k < 14; k++) begin
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 5) != 0);
            am = $urandom_range(0, 2);
            if (am == 2) accept();
            send_frame(d, 1'b0, sb, am == 1, -1);
            check_all("rnd_8n1");
        end
        accept();

        mode_p = 1'b1;
        send_frame(8'h07, 1'b0, 1'b1, 0, -1);
        check_all("t4_bad_parity");
        accept();
        send_frame(8'h07, 1'b1, 1'b1, 0, -1);
        check_all("t4_good_parity");
        accept();

        for (int k = 0; k < 10; k++) begin
            d  = 8'($urandom_range(0, 255));
            pb = ($urandom_range(0, 2) == 0) ? ~(^d) : ^d;
            sb = ($urandom_range(0, 5) != 0);
            am = $urandom_range(0, 2);
            if (am == 2) accept();
            send_frame(d, pb, sb, am == 1, -1);
            check_all("rnd_8e1");
        end
        accept();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
